// File: rtl/calipso_loader_pkg.sv
// Shared types and the ROM region map for the Calipso ROM download path.
package calipso_loader_pkg;

  localparam int NREG = 4;

  typedef enum logic [2:0] {
    S_BOOT,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    R_CPU,
    R_SND,
    R_GFX,
    R_PROM
  } region_t;

  // Inclusive byte ranges; entry index equals region_t value.
  localparam logic [NREG-1:0][24:0] REGION_BASE = {25'h08000, 25'h07000, 25'h06000, 25'h00000};
  localparam logic [NREG-1:0][24:0] REGION_LAST = {25'h0801F, 25'h07FFF, 25'h06FFF, 25'h05FFF};

endpackage

// File: rtl/rom_region_decode.sv
// Combinational download-address decoder: region hit, one-hot write select and
// region-relative byte address.
module rom_region_decode
  import calipso_loader_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [24:0]     addr_i,
  output logic            hit_o,
  output logic [NREG-1:0] we_o,
  output logic [AW-1:0]   rel_o
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  always_comb begin
    hit_o = 1'b0;
    we_o  = '0;
    rel_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_i >= REGION_BASE[i[IW-1:0]] && addr_i <= REGION_LAST[i[IW-1:0]]) begin
        hit_o             = 1'b1;
        we_o[i[IW-1:0]]   = 1'b1;
        rel_o             = AW'(addr_i - REGION_BASE[i[IW-1:0]]);
      end
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// Sequences the HPS ioctl ROM download onto one shared req/ack ROM write port.
// Optional LOADER_CHECKSUM_EN adds chk_sum, a wrapping sum of accepted bytes.
module rom_load_sequencer
  import calipso_loader_pkg::*;
#(
  parameter int NREG        = calipso_loader_pkg::NREG,
  parameter int HOLD_CYCLES = 16,
  parameter int AW          = 16
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic            rom_req,
  input  logic            rom_ack,
  output logic [NREG-1:0] rom_we,
  output logic [AW-1:0]   rom_addr,
  output logic [7:0]      rom_data,
  output logic            core_reset,
  output logic            load_done,
  output logic            err_drop
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]      chk_sum
`endif
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            req_q;
  logic            wait_q;
  logic [NREG-1:0] we_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      data_q;
  logic            core_rst_q;
  logic            done_q;
  logic            err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      chk_q;
`endif

  logic            dec_hit;
  logic [NREG-1:0] dec_we;
  logic [AW-1:0]   dec_rel;

  rom_region_decode #(
    .AW(AW)
  ) u_decode (
    .addr_i(ioctl_addr),
    .hit_o (dec_hit),
    .we_o  (dec_we),
    .rel_o (dec_rel)
  );

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= S_BOOT;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      wait_q     <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          if (ioctl_download) begin
            state_q <= S_LOAD;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
          end
        end
        // A write takes priority over a falling download so the byte is never lost.
        S_LOAD: begin
          if (ioctl_wr) begin
            if (dec_hit) begin
              req_q   <= 1'b1;
              wait_q  <= 1'b1;
              we_q    <= dec_we;
              addr_q  <= dec_rel;
              data_q  <= ioctl_dout;
              state_q <= S_WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end else if (!ioctl_download) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
          end
        end
        S_WRITE: begin
          if (ioctl_wr) begin
            err_q <= 1'b1;
          end
          if (rom_ack) begin
            req_q  <= 1'b0;
            wait_q <= 1'b0;
            we_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q  <= chk_q + data_q;
`endif
            if (ioctl_download) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_HOLD;
              cnt_q   <= HOLD_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (ioctl_download) begin
            state_q <= S_LOAD;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
          end else if (cnt_q == '0) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (ioctl_download) begin
            state_q    <= S_LOAD;
            core_rst_q <= 1'b1;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign rom_req    = req_q;
  assign rom_we     = we_q;
  assign rom_addr   = addr_q;
  assign rom_data   = data_q;
  assign core_reset = core_rst_q;
  assign load_done  = done_q;
  assign err_drop   = err_q;
`ifdef LOADER_CHECKSUM_EN
  assign chk_sum    = chk_q;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: boundary vector table, directed
// multi-cycle sequences and randomized downloads against an address-map model.
module tb_rom_load_sequencer;

  localparam int H    = 16;
  localparam int AW   = 16;
  localparam int NREG = 4;

  logic            clk = 1'b0;
  logic            RESET;
  logic            ioctl_download;
  logic            ioctl_wr;
  logic [24:0]     ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;
  logic            rom_req;
  logic            rom_ack;
  logic [NREG-1:0] rom_we;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data;
  logic            core_reset;
  logic            load_done;
  logic            err_drop;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      chk_sum;
`endif

  always #5 clk = ~clk;

  rom_load_sequencer #(
    .NREG(NREG),
    .HOLD_CYCLES(H),
    .AW(AW)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .rom_req       (rom_req),
    .rom_ack       (rom_ack),
    .rom_we        (rom_we),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .err_drop      (err_drop)
`ifdef LOADER_CHECKSUM_EN
    ,
    .chk_sum       (chk_sum)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  // Reference address map written as plain range arithmetic.
  function automatic logic model_map(input logic [24:0] a, output logic [3:0] we,
                                     output logic [15:0] rel);
    we  = 4'b0000;
    rel = 16'h0000;
    if (a < 25'h06000) begin
      we = 4'b0001; rel = a[15:0];
    end else if (a < 25'h07000) begin
      we = 4'b0010; rel = 16'(a - 25'h06000);
    end else if (a < 25'h08000) begin
      we = 4'b0100; rel = 16'(a - 25'h07000);
    end else if (a <= 25'h0801F) begin
      we = 4'b1000; rel = 16'(a - 25'h08000);
    end
    return we != 4'b0000;
  endfunction

  // Memory-side model: ack either tied high or after hi_cycles of req.
  logic ack_tie;
  int   hi_cycles;
  initial begin
    int wc;
    wc = 0;
    rom_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_tie) begin
        rom_ack = 1'b1;
      end else if (!rom_req) begin
        wc = 0;
        rom_ack = 1'b0;
      end else begin
        rom_ack = (wc >= hi_cycles - 1);
        wc++;
      end
    end
  end

  // Handshake monitor: records accepted writes and checks req-phase stability.
  logic        p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
  logic [3:0]  p_we = '0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_data = '0;
  always @(negedge clk) begin
    if (p_req && !p_ack && !p_rst)
      check("req_stable", {3'b000, rom_req, rom_we, rom_addr, rom_data},
            {3'b000, 1'b1, p_we, p_addr, p_data});
    if (rom_req && rom_ack && !RESET)
      obs_q.push_back('{rom_we, rom_addr, rom_data});
    p_req  <= rom_req;
    p_ack  <= rom_ack;
    p_rst  <= RESET;
    p_we   <= rom_we;
    p_addr <= rom_addr;
    p_data <= rom_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_obs(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({name, "_wr"}, {4'h0, obs_q[i].we, obs_q[i].addr, obs_q[i].data},
            {4'h0, exp_q[i].we, exp_q[i].addr, exp_q[i].data});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ioctl_wait && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) timeout(name);
  endtask

  int          hi;
  logic        c_req;
  logic [3:0]  c_we;
  logic [15:0] c_addr;

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    logic [3:0]  mw;
    logic [15:0] mr;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    c_req = rom_req; c_we = rom_we; c_addr = rom_addr;
    if (model_map(a, mw, mr)) exp_q.push_back('{mw, mr, d});
    hi = 0;
    while (ioctl_wait && hi < 64) begin
      hi++;
      step();
    end
    if (hi >= 64) timeout("write_wait");
  endtask

  // Drop download from S_LOAD; core_reset must fall exactly H+1 cycles later.
  task automatic hold_check(input string name);
    int n;
    ioctl_download = 1'b0;
    n = 0;
    while (core_reset && n < 4 * H) begin
      step();
      n++;
    end
    check({name, "_cycles"}, n, H + 1);
    check({name, "_done"}, load_done, 1'b1);
  endtask

  typedef struct {
    logic [24:0] addr;
    logic        hit;
    logic [3:0]  we;
    logic [15:0] rel;
  } vec_t;

  vec_t        vt[12];
  logic [24:0] ra;
  logic [3:0]  rw;
  logic [15:0] rr;
  logic        any_miss;
  int          n;

  initial begin
    vt[0]  = '{25'h00000, 1'b1, 4'b0001, 16'h0000};
    vt[1]  = '{25'h05FFF, 1'b1, 4'b0001, 16'h5FFF};
    vt[2]  = '{25'h06000, 1'b1, 4'b0010, 16'h0000};
    vt[3]  = '{25'h06FFF, 1'b1, 4'b0010, 16'h0FFF};
    vt[4]  = '{25'h07000, 1'b1, 4'b0100, 16'h0000};
    vt[5]  = '{25'h07FFF, 1'b1, 4'b0100, 16'h0FFF};
    vt[6]  = '{25'h08000, 1'b1, 4'b1000, 16'h0000};
    vt[7]  = '{25'h0801F, 1'b1, 4'b1000, 16'h001F};
    vt[8]  = '{25'h08020, 1'b0, 4'b0000, 16'h0000};
    vt[9]  = '{25'h0FFFF, 1'b0, 4'b0000, 16'h0000};
    vt[10] = '{25'h10000, 1'b0, 4'b0000, 16'h0000};
    vt[11] = '{25'h16000, 1'b0, 4'b0000, 16'h0000};

    RESET = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ack_tie = 1'b0; hi_cycles = 1;
    repeat (3) step();
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_req", rom_req, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", err_drop, 1'b0);
    check("rst_we", rom_we, 4'b0000);
    check("rst_addr", rom_addr, 16'h0000);
    check("rst_data", rom_data, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    check("rst_chk", chk_sum, 8'h00);
`endif
    RESET = 1'b0;
    step();
    check("boot_core_reset", core_reset, 1'b1);

    // Region boundary table
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      write_byte(vt[i].addr, 8'(i * 17 + 3));
      check("vec_req", c_req, vt[i].hit);
      if (vt[i].hit) begin
        check("vec_we", c_we, vt[i].we);
        check("vec_addr", c_addr, vt[i].rel);
      end else begin
        check("vec_err", err_drop, 1'b1);
      end
    end
    compare_obs("vec");
    hold_check("vec_hold");

    // Full CPU region with ack tied high
    ack_tie = 1'b1;
    ioctl_download = 1'b1;
    step();
    check("redl_core_reset", core_reset, 1'b1);
    check("redl_err_clear", err_drop, 1'b0);
    for (int a = 0; a < 'h6000; a++)
      write_byte(25'(a), 8'(a) ^ 8'(a >> 8));
    check("cpu_core_reset", core_reset, 1'b1);
    compare_obs("cpu");
    hold_check("cpu_hold");
    ack_tie = 1'b0;

    // Delayed ack, then unmapped write
    ioctl_download = 1'b1;
    step();
    hi_cycles = 5;
    write_byte(25'h06005, 8'hA5);
    check("dly_wait_cycles", hi, 5);
    check("dly_we", c_we, 4'b0010);
    check("dly_addr", c_addr, 16'h0005);
    hi_cycles = 1;
    write_byte(25'h08020, 8'h5A);
    check("unmap_req", c_req, 1'b0);
    check("unmap_err", err_drop, 1'b1);
    compare_obs("dly");
    hold_check("dly_hold");
    ioctl_download = 1'b1;
    step();
    check("err_clear", err_drop, 1'b0);

    // Write while busy is dropped; the first byte completes intact
    hi_cycles = 4;
    ioctl_wr = 1'b1; ioctl_addr = 25'h07010; ioctl_dout = 8'h3C;
    step();
    ioctl_wr = 1'b0;
    exp_q.push_back('{4'b0100, 16'h0010, 8'h3C});
    step();
    ioctl_wr = 1'b1; ioctl_addr = 25'h07011; ioctl_dout = 8'hC3;
    step();
    ioctl_wr = 1'b0;
    check("busy_err", err_drop, 1'b1);
    check("busy_addr_held", rom_addr, 16'h0010);
    check("busy_data_held", rom_data, 8'h3C);
    wait_idle("busy_idle");
    compare_obs("busy");

    // Download drops while waiting on ack
    ioctl_wr = 1'b1; ioctl_addr = 25'h08003; ioctl_dout = 8'h77;
    step();
    ioctl_wr = 1'b0;
    exp_q.push_back('{4'b1000, 16'h0003, 8'h77});
    ioctl_download = 1'b0;
    step();
    check("drop_req_held", rom_req, 1'b1);
    wait_idle("drop_idle");
    compare_obs("drop");
    n = 0;
    while (core_reset && n < 4 * H) begin
      step();
      n++;
    end
    check("drop_hold_cycles", n, H);
    check("drop_done", load_done, 1'b1);
    ioctl_download = 1'b1;
    step();
    check("run_redl_core_reset", core_reset, 1'b1);

    // Checksum bytes, then RESET while a write is outstanding
    hi_cycles = 1;
    write_byte(25'h08000, 8'h01);
    write_byte(25'h08001, 8'hFF);
    write_byte(25'h08002, 8'h10);
    compare_obs("chk");
`ifdef LOADER_CHECKSUM_EN
    check("chk_sum", chk_sum, 8'h10);
`endif
    check("pre_rst_done", load_done, 1'b1);
    hi_cycles = 10;
    ioctl_wr = 1'b1; ioctl_addr = 25'h08004; ioctl_dout = 8'h55;
    step();
    ioctl_wr = 1'b0;
    step();
    check("abort_req_before", rom_req, 1'b1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("abort_req", rom_req, 1'b0);
    check("abort_core_reset", core_reset, 1'b1);
    check("abort_done", load_done, 1'b0);
    check("abort_wait", ioctl_wait, 1'b0);
    check("abort_we", rom_we, 4'b0000);
`ifdef LOADER_CHECKSUM_EN
    check("abort_chk", chk_sum, 8'h00);
`endif
    step();
    compare_obs("abort");

    // Randomized downloads against the model
    for (int r = 0; r < 4; r++) begin
      ioctl_download = 1'b1;
      step();
      any_miss = 1'b0;
      for (int k = 0; k < 50; k++) begin
        case ($urandom_range(0, 5))
          0: ra = 25'($urandom_range(0, 'h5FFF));
          1: ra = 25'('h6000 + $urandom_range(0, 'hFFF));
          2: ra = 25'('h7000 + $urandom_range(0, 'hFFF));
          3: ra = 25'('h8000 + $urandom_range(0, 'h1F));
          4: ra = 25'('h8020 + $urandom_range(0, 'h7FDF));
          default: ra = {9'($urandom_range(1, 511)), 16'($urandom)};
        endcase
        if (!model_map(ra, rw, rr)) any_miss = 1'b1;
        hi_cycles = $urandom_range(1, 4);
        write_byte(ra, 8'($urandom));
      end
      check("rnd_err", err_drop, any_miss);
      compare_obs("rnd");
      hold_check("rnd_hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
